// File: rtl/mfp_conv_window_if.sv
// Pixel-in / window-out bus of the convolution window builder.
// The master drives pixels and the shared advance; the slave returns ready and windows.
interface mfp_conv_window_if #(
    parameter int unsigned DataW = 8,
    parameter int unsigned ArrL  = 5
) ();
    logic                    en;
    logic                    in_valid;
    logic [DataW-1:0]        in_data;
    logic                    in_sol;
    logic                    in_ready;
    logic                    out_valid;
    logic [DataW*ArrL-1:0]   out_win;
    logic                    out_eol;

    modport master (
        output en, in_valid, in_data, in_sol,
        input  in_ready, out_valid, out_win, out_eol
    );

    modport slave (
        input  en, in_valid, in_data, in_sol,
        output in_ready, out_valid, out_win, out_eol
    );
endinterface

// File: rtl/mfp_conv_window.sv
// Streaming centred ArrL-tap window builder with line-edge padding, one window per pixel.
// Define MFP_WIN_ZEROPAD_EN to pad line edges with zero instead of replicating edge pixels.
module mfp_conv_window #(
    parameter int unsigned DataW = 8,
    parameter int unsigned ArrL  = 5,
    parameter int unsigned LineW = 640,
    parameter int unsigned CntW  = 10
) (
    input logic               clk,
    input logic               aclr_n,
    mfp_conv_window_if.slave  win_bus
);
    localparam int unsigned H     = (ArrL - 1) / 2;
    localparam int unsigned WinW  = DataW * ArrL;
    localparam int unsigned FcntW = (H > 1) ? $clog2(H) : 1;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_FLUSH = 2'd2;

    logic [1:0]       r_state;
    logic [CntW-1:0]  r_col;
    logic [FcntW-1:0] r_fcnt;
    logic [WinW-1:0]  r_taps;
    logic [WinW-1:0]  r_out_win;
    logic             r_out_valid;
    logic             r_out_eol;

    logic [1:0]       w_state_d;
    logic [CntW-1:0]  w_col_d;
    logic [FcntW-1:0] w_fcnt_d;
    logic [WinW-1:0]  w_taps_d;
    logic             w_emit;
    logic             w_eol;
    logic             w_accept;
    logic [WinW-1:0]  w_sol_load;
    logic [DataW-1:0] w_pad;

`ifdef MFP_WIN_ZEROPAD_EN
    assign w_sol_load = {win_bus.in_data, {(WinW - DataW){1'b0}}};
    assign w_pad      = '0;
`else
    assign w_sol_load = {ArrL{win_bus.in_data}};
    assign w_pad      = r_taps[WinW-1 -: DataW];
`endif

    assign win_bus.in_ready  = win_bus.en && (r_state != ST_FLUSH);
    assign w_accept          = win_bus.in_valid && win_bus.in_ready;
    assign win_bus.out_valid = r_out_valid;
    assign win_bus.out_win   = r_out_win;
    assign win_bus.out_eol   = r_out_eol;

    always_comb begin
        w_state_d = r_state;
        w_col_d   = r_col;
        w_fcnt_d  = r_fcnt;
        w_taps_d  = r_taps;
        w_emit    = 1'b0;
        w_eol     = 1'b0;
        if (win_bus.en) begin
            case (r_state)
                ST_IDLE, ST_RUN: begin
                    if (w_accept) begin
                        if (win_bus.in_sol) begin
                            // start-of-line wins in RUN too: aborts the line without eol
                            w_taps_d  = w_sol_load;
                            w_col_d   = CntW'(1);
                            w_fcnt_d  = '0;
                            w_state_d = ST_RUN;
                        end else if (r_state == ST_RUN) begin
                            w_taps_d = {win_bus.in_data, r_taps[WinW-1:DataW]};
                            w_col_d  = r_col + CntW'(1);
                            w_emit   = (r_col >= CntW'(H));
                            if (r_col == CntW'(LineW - 1)) begin
                                w_state_d = ST_FLUSH;
                                w_fcnt_d  = '0;
                            end
                        end
                    end
                end
                ST_FLUSH: begin
                    w_taps_d = {w_pad, r_taps[WinW-1:DataW]};
                    w_emit   = 1'b1;
                    if (r_fcnt == FcntW'(H - 1)) begin
                        w_eol     = 1'b1;
                        w_state_d = ST_IDLE;
                        w_col_d   = '0;
                    end else begin
                        w_fcnt_d = r_fcnt + FcntW'(1);
                    end
                end
                default: w_state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge aclr_n) begin
        if (!aclr_n) begin
            r_state     <= ST_IDLE;
            r_col       <= '0;
            r_fcnt      <= '0;
            r_taps      <= '0;
            r_out_win   <= '0;
            r_out_valid <= 1'b0;
            r_out_eol   <= 1'b0;
        end else if (win_bus.en) begin
            r_state     <= w_state_d;
            r_col       <= w_col_d;
            r_fcnt      <= w_fcnt_d;
            r_taps      <= w_taps_d;
            r_out_valid <= w_emit;
            r_out_eol   <= w_eol;
            if (w_emit) begin
                r_out_win <= w_taps_d;
            end
        end
    end
endmodule

// File: tb/tb_mfp_conv_window.sv
// Bench for mfp_conv_window: line-level window model plus directed literal checks.
module tb_mfp_conv_window;
    localparam int DataW = 8;
    localparam int ArrL  = 5;
    localparam int LineW = 8;
    localparam int CntW  = 4;
    localparam int H     = (ArrL - 1) / 2;
    localparam int WinW  = DataW * ArrL;
`ifdef MFP_WIN_ZEROPAD_EN
    localparam bit ZeroPad = 1'b1;
`else
    localparam bit ZeroPad = 1'b0;
`endif

    logic clk = 1'b0;
    logic aclr_n = 1'b0;
    always #5 clk = ~clk;

    mfp_conv_window_if #(.DataW(DataW), .ArrL(ArrL)) bus ();

    mfp_conv_window #(.DataW(DataW), .ArrL(ArrL), .LineW(LineW), .CntW(CntW)) dut (
        .clk    (clk),
        .aclr_n (aclr_n),
        .win_bus(bus)
    );

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    function automatic logic [WinW-1:0] pk(input int t0, input int t1, input int t2,
                                           input int t3, input int t4);
        logic [WinW-1:0] r;
        r[0*DataW +: DataW] = t0[DataW-1:0];
        r[1*DataW +: DataW] = t1[DataW-1:0];
        r[2*DataW +: DataW] = t2[DataW-1:0];
        r[3*DataW +: DataW] = t3[DataW-1:0];
        r[4*DataW +: DataW] = t4[DataW-1:0];
        return r;
    endfunction

    // Line-level model: every centre x gets taps x-H..x+H, out-of-line indices padded.
    typedef struct packed {
        logic [WinW-1:0] win;
        logic            eol;
    } exp_t;

    exp_t q[$];
    int   pix[LineW];
    int   n_pix = 0;
    bit   in_line = 1'b0;
    bit   edge_en = 1'b1;
    bit   s_en = 1'b0, s_acc = 1'b0, s_sol = 1'b0;
    int   s_data = 0;
    int   n_win = 0, n_eol = 0;
    logic [WinW-1:0] last_eol_win = '0;

    function automatic logic [WinW-1:0] model_win(input int x);
        logic [WinW-1:0] r;
        int idx, v;
        for (int k = 0; k < ArrL; k++) begin
            idx = x - H + k;
            if (idx < 0)          v = ZeroPad ? 0 : pix[0];
            else if (idx >= LineW) v = ZeroPad ? 0 : pix[LineW-1];
            else                  v = pix[idx];
            r[k*DataW +: DataW] = v[DataW-1:0];
        end
        return r;
    endfunction

    initial forever begin
        @(negedge clk);
        #4;
        s_en   = bus.en;
        s_acc  = bus.en && bus.in_valid && bus.in_ready;
        s_sol  = bus.in_sol;
        s_data = int'(bus.in_data);
    end

    initial forever begin
        exp_t e;
        @(posedge clk or negedge aclr_n);
        if (!aclr_n) begin
            q.delete();
            in_line = 1'b0;
            n_pix   = 0;
            edge_en = 1'b1;
        end else begin
            edge_en = s_en;
            if (s_acc) begin
                if (s_sol) begin
                    in_line = 1'b1;
                    n_pix   = 0;
                end
                if (in_line) begin
                    pix[n_pix] = s_data;
                    n_pix++;
                    if (n_pix - 1 >= H) begin
                        e.win = model_win(n_pix - 1 - H);
                        e.eol = 1'b0;
                        q.push_back(e);
                    end
                    if (n_pix == LineW) begin
                        for (int x = LineW - H; x < LineW; x++) begin
                            e.win = model_win(x);
                            e.eol = (x == LineW - 1);
                            q.push_back(e);
                        end
                        in_line = 1'b0;
                    end
                end
            end
        end
    end

    // Compare process: new pulses pop the model; frozen cycles must hold outputs.
    initial begin
        logic            p_valid, p_eol;
        logic [WinW-1:0] p_win;
        bit              have_prev;
        exp_t            e;
        have_prev = 1'b0;
        p_valid = 1'b0; p_eol = 1'b0; p_win = '0;
        forever begin
            @(negedge clk);
            if (aclr_n && have_prev) begin
                if (!edge_en) begin
                    chk("hold_valid", bus.out_valid, p_valid);
                    chk("hold_win", bus.out_win, p_win);
                    chk("hold_eol", bus.out_eol, p_eol);
                end else if (bus.out_valid) begin
                    if (q.size() == 0) begin
                        chk("spurious_valid", bus.out_valid, 1'b0);
                    end else begin
                        e = q.pop_front();
                        chk("win", bus.out_win, e.win);
                        chk("eol", bus.out_eol, e.eol);
                    end
                    n_win++;
                    if (bus.out_eol) begin
                        n_eol++;
                        last_eol_win = bus.out_win;
                    end
                end
            end
            p_valid   = bus.out_valid;
            p_win     = bus.out_win;
            p_eol     = bus.out_eol;
            have_prev = aclr_n;
        end
    end

    task automatic send(input int d, input bit sol);
        int g;
        g = 0;
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_data  = d[DataW-1:0];
        bus.in_sol   = sol;
        #1;
        while (!(bus.en && bus.in_ready) && g < 40) begin
            @(negedge clk);
            #1;
            g++;
        end
        if (g >= 40) begin
            checks++;
            failures++;
            $display("FAIL accept_timeout actual=%0d required=accepted", d);
            bus.in_valid = 1'b0;
        end else begin
            @(posedge clk);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            bus.in_valid = 1'b0;
            bus.in_sol   = 1'b0;
        end
    endtask

    task automatic en_gap(input int n);
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.in_sol   = 1'b0;
        bus.en       = 1'b0;
        repeat (n) @(negedge clk);
        bus.en = 1'b1;
    endtask

    task automatic drain();
        int g;
        g = 0;
        while (q.size() != 0 && g < 60) begin
            @(negedge clk);
            g++;
        end
        idle(3);
        chk("drain_empty", q.size(), 0);
    endtask

    initial begin
        int w0, e0, low;
        bus.en = 1'b1;
        bus.in_valid = 1'b0;
        bus.in_sol = 1'b0;
        bus.in_data = '0;

        // Reset state
        #2;
        chk("rst_valid", bus.out_valid, 1'b0);
        chk("rst_win", bus.out_win, '0);
        chk("rst_eol", bus.out_eol, 1'b0);
        repeat (2) @(negedge clk);
        #1 aclr_n = 1'b1;
        #1 chk("rst_ready", bus.in_ready, 1'b1);

        // Pixels without start-of-line are dropped
        for (int i = 5; i < 9; i++) send(i, 1'b0);
        idle(5);
        chk("idle_no_windows", n_win, 0);

        // Basic line 1..8
        w0 = n_win; e0 = n_eol;
        for (int i = 1; i <= LineW; i++) begin
            send(i, i == 1);
            if (i == 3) begin
                #1;
                chk("first_valid", bus.out_valid, 1'b1);
                chk("first_win", bus.out_win, ZeroPad ? pk(0, 0, 1, 2, 3) : pk(1, 1, 1, 2, 3));
            end
        end
        low = 0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            bus.in_valid = 1'b0;
            bus.in_sol   = 1'b0;
            #1;
            if (!bus.in_ready) low++;
        end
        chk("ready_low_cycles", low, 2);
        drain();
        chk("basic_count", n_win - w0, LineW);
        chk("basic_eol_count", n_eol - e0, 1);
        chk("last_win", last_eol_win, ZeroPad ? pk(6, 7, 8, 0, 0) : pk(6, 7, 8, 8, 8));

        // en dropped mid-line and during flush
        w0 = n_win; e0 = n_eol;
        for (int i = 0; i < 4; i++) send(30 + i, i == 0);
        en_gap(3);
        for (int i = 4; i < LineW; i++) send(30 + i, 1'b0);
        en_gap(3);
        drain();
        chk("en_count", n_win - w0, LineW);
        chk("en_eol_count", n_eol - e0, 1);

        // Abort after 4 pixels, new line 9..16
        w0 = n_win; e0 = n_eol;
        for (int i = 1; i <= 4; i++) send(i, i == 1);
        for (int i = 9; i <= 16; i++) begin
            send(i, i == 9);
            if (i == 11) begin
                #1;
                chk("abort_first_win", bus.out_win,
                    ZeroPad ? pk(0, 0, 9, 10, 11) : pk(9, 9, 9, 10, 11));
            end
        end
        drain();
        chk("abort_count", n_win - w0, 2 + LineW);
        chk("abort_eol_count", n_eol - e0, 1);

        // Async reset while flushing
        for (int i = 0; i < LineW; i++) send(40 + i, i == 0);
        #2;
        bus.in_valid = 1'b0;
        aclr_n = 1'b0;
        #1;
        chk("arst_valid", bus.out_valid, 1'b0);
        chk("arst_win", bus.out_win, '0);
        chk("arst_eol", bus.out_eol, 1'b0);
        @(negedge clk);
        #1 aclr_n = 1'b1;
        w0 = n_win; e0 = n_eol;
        for (int i = 0; i < LineW; i++) send(50 + i, i == 0);
        drain();
        chk("post_rst_count", n_win - w0, LineW);
        chk("post_rst_eol_count", n_eol - e0, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end
endmodule
